// File: rtl/axi_burst_sram_slave_pkg.sv
// Shared definitions for the burst SRAM responder: FSM encoding and AXI constants.
package axi_burst_sram_slave_pkg;

  localparam int LEN_W      = 4;
  localparam int WORD_BYTES = 4;
  localparam logic [1:0] OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    RLAT,
    RDATA,
    WDATA,
    WRESP
  } state_t;

endpackage

// File: rtl/axi_burst_sram_slave_sram.sv
// Word-organised SRAM with one combinational read port and one byte-enabled write port.
module sram_bytewe
  import axi_burst_sram_slave_pkg::*;
#(
  parameter int    ADDR_W    = 12,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_strb,
  input  logic [31:0]       wr_data
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (wr_strb[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_burst_sram_slave.sv
// AXI3-style INCR burst responder in front of a byte-writable SRAM; one transaction at a time,
// optional first-beat read latency to model slow memory.
module axi_burst_sram_slave
  import axi_burst_sram_slave_pkg::*;
#(
  parameter int    ADDR_W    = 12,
  parameter int    RD_LAT    = 0,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic        bvalid,
  input  logic        bready,
  output logic        proto_err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  BEAT_ONE = LEN_W'(1);
  localparam logic [3:0]        LAT_LAST = 4'(RD_LAT - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  beat;
  logic [3:0]        lat_cnt;
  logic [ADDR_W-1:0] ar_word;
  logic [ADDR_W-1:0] aw_word;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic              last_beat;
  logic              unused_bits;

  // Byte offsets and address bits above the memory are dropped, so higher addresses alias.
  assign ar_word   = araddr[ADDR_W+1:2];
  assign aw_word   = awaddr[ADDR_W+1:2];
  assign last_beat = (beat == len);

  assign unused_bits = ^{arsize, awsize, araddr[31:ADDR_W+2], araddr[1:0],
                         awaddr[31:ADDR_W+2], awaddr[1:0]};

  assign awready = (state == IDLE);
  assign arready = (state == IDLE) && !awvalid;

  // Read port looks one word ahead during a read so the next beat can be registered on handshake.
  always_comb begin
    rd_addr = addr;
    if (state == IDLE)       rd_addr = ar_word;
    else if (state == RDATA) rd_addr = addr + ADDR_ONE;
  end

  assign mem_we = (state == WDATA) && wvalid && wready;

  sram_bytewe #(
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_sram (
    .clk    (clk),
    .rd_addr(rd_addr),
    .rd_data(mem_rdata),
    .we     (mem_we),
    .wr_addr(addr),
    .wr_strb(wstrb),
    .wr_data(wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      len       <= '0;
      beat      <= '0;
      lat_cnt   <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (awvalid) begin
            addr   <= aw_word;
            len    <= awlen;
            beat   <= '0;
            wready <= 1'b1;
            state  <= WDATA;
          end else if (arvalid) begin
            addr    <= ar_word;
            len     <= arlen;
            beat    <= '0;
            lat_cnt <= '0;
            if (RD_LAT == 0) begin
              rdata  <= mem_rdata;
              rvalid <= 1'b1;
              rlast  <= (arlen == '0);
              state  <= RDATA;
            end else begin
              state <= RLAT;
            end
          end
        end
        RLAT: begin
          if (lat_cnt == LAT_LAST) begin
            rdata  <= mem_rdata;
            rvalid <= 1'b1;
            rlast  <= (len == '0);
            state  <= RDATA;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        RDATA: begin
          if (rready) begin
            if (last_beat) begin
              rvalid <= 1'b0;
              rlast  <= 1'b0;
              state  <= IDLE;
            end else begin
              addr  <= addr + ADDR_ONE;
              beat  <= beat + BEAT_ONE;
              rdata <= mem_rdata;
              rlast <= ((beat + BEAT_ONE) == len);
            end
          end
        end
        WDATA: begin
          // The beat count ends the burst; wlast is only cross-checked.
          if (wvalid) begin
            if (wlast != last_beat) proto_err <= 1'b1;
            if (last_beat) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              state  <= WRESP;
            end else begin
              addr <= addr + ADDR_ONE;
              beat <= beat + BEAT_ONE;
            end
          end
        end
        WRESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
